// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Also holds the baud divisors for a 100 MHz system clock.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned BAUD_DIV_9600   = 10416;
    localparam int unsigned BAUD_DIV_19200  = 5208;
    localparam int unsigned BAUD_DIV_38400  = 2604;
    localparam int unsigned BAUD_DIV_115200 = 868;

    // A FIFO word carries the data plus the frame and parity flags.
    function automatic int unsigned fifo_width(input int unsigned data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Serial line, frame configuration and valid/ready word output of
// the UART receiver. The master side is the receiver itself.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 data_in;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 two_stop;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;
    logic                 frame_err;
    logic                 valid;
    logic                 ready;
    logic                 overrun;
    logic                 rts;

    modport master (
        input  data_in, parity_en, parity_odd, two_stop, ready,
        output data_out, parity_err, frame_err, valid, overrun, rts
    );

    modport slave (
        output data_in, parity_en, parity_odd, two_stop, ready,
        input  data_out, parity_err, frame_err, valid, overrun, rts
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// A write while full is accepted only when a read frees a slot.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr && !do_rd) count_d = count_q + 1'b1;
        if (do_rd && !do_wr) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: synchroniser, mid-bit sampling FSM with runtime
// parity/stop selection, and a show-ahead word FIFO with RTS.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RTS_MARGIN = 2
) (
    input logic            clk,
    input logic            rst_n,
    uart_rx_param_if.master bus
);
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam int unsigned WW = fifo_width(DATA_BITS);
    localparam int unsigned NW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] RTS_THR  = NW'(FIFO_DEPTH - RTS_MARGIN);

    logic                 rx_meta_q, rxs_q;
    logic                 rxs_prev_q, rxs_prev_d;
    logic [1:0]           sync_vld_q;
    logic                 fall;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bitn_q, bitn_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 two_stop_q, two_stop_d;
    logic                 overrun_q, overrun_d;
    logic                 rts_q, rts_d;
    logic                 expire, push, push_fe, pop;
    logic [WW-1:0]        fifo_rd;
    logic                 fifo_full, fifo_empty;
    logic [NW-1:0]        fifo_count;

    // The edge history only arms once the synchroniser holds real line
    // data, so a line that is low at reset release is not a start.
    assign rxs_prev_d = sync_vld_q[1] & rxs_q;
    assign fall       = rxs_prev_q & ~rxs_q;
    assign expire     = (cnt_q == '0);
    assign push_fe    = ferr_q | ~rxs_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = expire ? cnt_q : cnt_q - 1'b1;
        bitn_d     = bitn_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        push       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    cnt_d      = CNT_HALF;
                    bitn_d     = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    par_en_d   = bus.parity_en;
                    par_odd_d  = bus.parity_odd;
                    two_stop_d = bus.two_stop;
                end
            end
            S_START: begin
                if (expire) begin
                    state_d = rxs_q ? S_IDLE : S_DATA;
                    cnt_d   = CNT_FULL;
                end
            end
            S_DATA: begin
                if (expire) begin
                    cnt_d  = CNT_FULL;
                    bitn_d = bitn_q + 1'b1;
                    if (MSB_FIRST)
                        shreg_d = {shreg_q[DATA_BITS-2:0], rxs_q};
                    else
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                    if (bitn_q == LAST_BIT)
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (expire) begin
                    cnt_d   = CNT_FULL;
                    perr_d  = (^shreg_q) ^ rxs_q ^ par_odd_q;
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (expire) begin
                    cnt_d  = CNT_FULL;
                    ferr_d = push_fe;
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                if (expire) begin
                    ferr_d  = push_fe;
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop       = ~fifo_empty & bus.ready;
    assign overrun_d = push & fifo_full & ~pop;
    assign rts_d     = (fifo_count < RTS_THR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            sync_vld_q <= '0;
            rxs_prev_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bitn_q     <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            overrun_q  <= 1'b0;
            rts_q      <= 1'b1;
        end else begin
            rx_meta_q  <= bus.data_in;
            rxs_q      <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rxs_prev_q <= rxs_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitn_q     <= bitn_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            overrun_q  <= overrun_d;
            rts_q      <= rts_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({push_fe, perr_q, shreg_q}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.valid      = ~fifo_empty;
    assign bus.data_out   = fifo_empty ? '0 : fifo_rd[DATA_BITS-1:0];
    assign bus.parity_err = ~fifo_empty & fifo_rd[DATA_BITS];
    assign bus.frame_err  = ~fifo_empty & fifo_rd[DATA_BITS+1];
    assign bus.overrun    = overrun_q;
    assign bus.rts        = rts_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param: frames are built
// from a bit-level line model, expected words queued, popped on output.
module tb_uart_rx_param;
    localparam int unsigned BAUD   = 16;
    localparam int unsigned DB     = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MARGIN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    int   ovr_seen = 0;
    int   ovr_exp  = 0;
    logic [DB+1:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param_if #(.DATA_BITS(DB)) bus ();

    uart_rx_param #(
        .BAUD_DIV   (BAUD),
        .DATA_BITS  (DB),
        .MSB_FIRST  (1'b0),
        .FIFO_DEPTH (DEPTH),
        .RTS_MARGIN (MARGIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    // Monitor: pop the scoreboard whenever a word is handed over.
    always @(negedge clk) begin
        logic [DB+1:0] w;
        if (rst_n) begin
            if (bus.overrun) ovr_seen++;
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             {bus.frame_err, bus.parity_err, bus.data_out});
                end else begin
                    w = exp_q.pop_front();
                    check("word", {bus.frame_err, bus.parity_err, bus.data_out}, w);
                end
            end else if (!bus.valid) begin
                check("idle_outputs_zero",
                      {bus.frame_err, bus.parity_err, bus.data_out}, 0);
            end
        end
    end

    // Line model: start, data LSB first, optional parity, stop bits, idle.
    task automatic send_frame(input logic [DB-1:0] d, input logic pen,
                              input logic podd, input logic two,
                              input logic pflip, input logic s1,
                              input logic s2, input int gap);
        int   ones, tot;
        logic p, pe, fe;
        ones = $countones(d);
        p    = (podd ? ~ones[0] : ones[0]) ^ pflip;
        tot  = ones + int'(p);
        pe   = pen && (((tot % 2) == 1) != podd);
        fe   = !s1 || (two && !s2);
        if (!bus.ready && exp_q.size() >= DEPTH) ovr_exp++;
        else exp_q.push_back({fe, pe, d});
        bus.parity_en  = pen;
        bus.parity_odd = podd;
        bus.two_stop   = two;
        bus.data_in    = 1'b0;
        for (int i = 0; i < BAUD; i++) begin
            tick();
            if (i == 8) begin
                bus.parity_en  = 1'($urandom);
                bus.parity_odd = 1'($urandom);
                bus.two_stop   = 1'($urandom);
            end
        end
        for (int i = 0; i < DB; i++) begin
            bus.data_in = d[i];
            repeat (BAUD) tick();
        end
        if (pen) begin
            bus.data_in = p;
            repeat (BAUD) tick();
        end
        bus.data_in = s1;
        repeat (BAUD) tick();
        if (two) begin
            bus.data_in = s2;
            repeat (BAUD) tick();
        end
        bus.data_in = 1'b1;
        repeat (gap * BAUD) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int seen;
        bus.data_in    = 1'b1;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;
        bus.ready      = 1'b1;
        repeat (3) tick();
        check("rst_valid", bus.valid, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_perr", bus.parity_err, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_rts", bus.rts, 1);
        rst_n = 1'b1;
        repeat (5) tick();

        // Basic frame, valid for exactly one cycle.
        k = cyc;
        fork
            send_frame(8'hA5, 0, 0, 0, 0, 1, 1, 2);
            begin
                wait_cyc(k + 154);
                check("basic_valid_pre", bus.valid, 0);
                wait_cyc(k + 155);
                check("basic_valid", bus.valid, 1);
                wait_cyc(k + 156);
                check("basic_valid_post", bus.valid, 0);
            end
        join

        send_frame(8'h07, 1, 0, 0, 0, 1, 1, 2);
        send_frame(8'h07, 1, 0, 0, 1, 1, 1, 2);

        // Bad second stop, then a held-low line must not restart.
        send_frame(8'h5A, 0, 0, 1, 0, 1, 0, 0);
        bus.data_in = 1'b0;
        repeat (5 * BAUD) tick();
        check("break_no_word", bus.valid, 0);
        bus.data_in = 1'b1;
        repeat (2 * BAUD) tick();
        send_frame(8'hC3, 0, 0, 0, 0, 1, 1, 2);

        // Glitch shorter than half a bit.
        bus.data_in = 1'b0;
        repeat (5) tick();
        bus.data_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 * BAUD; i++) begin
            tick();
            if (bus.valid) seen++;
        end
        check("glitch_no_word", seen, 0);
        send_frame(8'h96, 0, 0, 0, 0, 1, 1, 2);

        // Flow control with the consumer stalled.
        bus.ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            k = cyc;
            fork
                send_frame(8'(n), 0, 0, 0, 0, 1, 1, 2);
                begin
                    wait_cyc(k + 154);
                    if (n == 1) check("flow_valid_pre", bus.valid, 0);
                    if (n == 5) check("ovr_pre", bus.overrun, 0);
                    wait_cyc(k + 155);
                    if (n == 1) check("flow_valid", bus.valid, 1);
                    if (n == 2) check("rts_hold", bus.rts, 1);
                    if (n == 5) check("ovr_pulse", bus.overrun, 1);
                    wait_cyc(k + 156);
                    if (n == 1) check("rts_one_word", bus.rts, 1);
                    if (n == 2) check("rts_drop", bus.rts, 0);
                    if (n == 5) check("ovr_end", bus.overrun, 0);
                end
            join
        end
        bus.ready = 1'b1;
        repeat (10) tick();
        check("flow_drained", exp_q.size(), 0);
        check("rts_restored", bus.rts, 1);

        // Reset during data bit 3 flushes the FIFO.
        bus.ready = 1'b0;
        send_frame(8'h11, 0, 0, 0, 0, 1, 1, 1);
        send_frame(8'h22, 0, 0, 0, 0, 1, 1, 1);
        check("pre_reset_rts", bus.rts, 0);
        bus.data_in = 1'b0;
        repeat (4 * BAUD + BAUD / 2) tick();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        check("mid_rst_valid", bus.valid, 0);
        check("mid_rst_rts", bus.rts, 1);
        rst_n = 1'b1;
        repeat (3 * BAUD) tick();
        check("post_rst_low_no_word", bus.valid, 0);
        bus.data_in = 1'b1;
        repeat (2 * BAUD) tick();
        bus.ready = 1'b1;
        send_frame(8'h3C, 0, 0, 0, 0, 1, 1, 2);

        // Random frames and configurations.
        for (int i = 0; i < 16; i++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) != 0),
                       int'($urandom_range(1, 2)));
        end

        repeat (40) tick();
        check("queue_empty", exp_q.size(), 0);
        check("overrun_count", ovr_seen, ovr_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: 2-FF input synchroniser, mid-bit sampling, runtime-selectable parity and stop bits, per-word parity/framing flags, and a show-ahead receive FIFO with valid/ready output and RTS flow control. Sits between the serial pin and the packet/CRC logic. It replaces the fixed 8-bit, MSB-first, handshake-less receiver.

## Interface
- BAUD_DIV, 868: clock cycles per bit (868 = 115200 Bd @ 100 MHz); must be >= 4
- DATA_BITS, 8: data bits per frame, 5..9
- MSB_FIRST, 0: 0 = LSB first (standard), 1 = MSB first (legacy links)
- FIFO_DEPTH, 8: receive FIFO entries, power of two, >= 2
- RTS_MARGIN, 2: free entries left when RTS drops; 1..FIFO_DEPTH-1
- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- DATA_IN  in  1  serial line, idle high
- Parity_en  in  1  1 = frame carries a parity bit
- Parity_odd  in  1  1 = odd parity, 0 = even
- Two_stop  in  1  1 = two stop bits
- DATA_OUT  out  DATA_BITS  head-of-FIFO word
- Parity_err  out  1  head word parity mismatch
- Frame_err  out  1  head word had a stop bit sampled 0
- Valid  out  1  FIFO non-empty; DATA_OUT and flags are valid
- Ready  in  1  consumer accepts head word
- Overrun  out  1  one-cycle pulse: completed word dropped, FIFO full
- RTS  out  1  1 = peer may send; 0 = FIFO at/over threshold

## Operation
- Synchroniser flops reset to 1. All FSM decisions use the synchronised line `rxs`.
- Config inputs are latched on start-bit detection and held for the whole frame. Changes mid-frame do not affect the frame in progress.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE:** on a 1→0 transition of `rxs`, load the bit counter with BAUD_DIV/2-1 and go to START. A line already low when IDLE is entered (break, post-reset) is not a start.
- **START:** on counter expiry, sample `rxs`. If 1, it was a false start: return to IDLE. If 0, reload the counter with BAUD_DIV-1 and go to DATA.
- **DATA:** sample on each expiry. The shift direction follows MSB_FIRST. After DATA_BITS samples, go to PARITY if Parity_en is set, else to STOP1.
- **PARITY:** sample the parity bit p. Parity_err = (^data ^ p) ^ Parity_odd.
- **STOP1:** a sample of 0 sets the frame error. If Two_stop is set, go to STOP2; otherwise push and go to IDLE.
- **STOP2:** a sample of 0 sets the frame error. Push and go to IDLE.
- **Push:** {Frame_err, Parity_err, data} is written to the FIFO at the final stop sample. Words with errors are still delivered.
- **FIFO:** show-ahead. A pop occurs when Valid && Ready.
  - While Valid = 0, DATA_OUT, Parity_err and Frame_err are forced to 0.
  - Push while full and no pop: the word is discarded and Overrun pulses. Stored contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, and the count stays FIFO_DEPTH.
  - Push and pop in the same cycle while empty: not possible, since Valid = 0.
- **RTS:** registered. RTS = (count < FIFO_DEPTH-RTS_MARGIN).

## Timing
- Reset values: Valid 0, DATA_OUT 0, Parity_err 0, Frame_err 0, Overrun 0, RTS 1. FSM in IDLE, FIFO empty.
- Input latency: 2 cycles (synchroniser).
- Start sample falls BAUD_DIV/2 cycles after the synchronised falling edge. Each later sample is exactly BAUD_DIV cycles after the previous one.
- Push to output: Valid rises 1 cycle after the final stop sample when the FIFO was empty. Overrun asserts in that same cycle.
- RTS updates 1 cycle after any count change.
- FSM re-enters IDLE 1 cycle after the final stop sample, i.e. mid stop-bit. It can therefore catch back-to-back frames.
- Reset mid-frame: the partial word is lost and the FIFO is flushed. After release, a frame is received only after a fresh 1→0 edge.
- Counter width: $clog2(BAUD_DIV). FIFO count width: $clog2(FIFO_DEPTH)+1.

## Structure
- Package `uart_pkg` holds:
  - the state enum
  - the parity-mode constants
  - the BAUD_DIV constants for 100 MHz: 9600 = 10416, 19200 = 5208, 38400 = 2604, 115200 = 868
  - the FIFO word-width function DATA_BITS+2
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO with count output, parametrised by width and depth, reused by the TX side.

## Test plan
All scenarios use BAUD_DIV=16, DATA_BITS=8, Ready=1 unless stated.
- **Basic frame:** 0xA5, LSB first, no parity, 1 stop → Valid for 1 cycle, DATA_OUT=0xA5, both error flags 0.
- **Parity:** even parity, 0x07 with p=1 → Parity_err=0. The same frame with p=0 → word 0x07 with Parity_err=1.
- **Framing:** Two_stop=1, second stop bit driven 0 → Frame_err=1, DATA_OUT correct. With the line held low afterwards, no further frames until the line returns high and falls again.
- **Glitch rejection:** line low for 5 cycles (< 8) → no push, FSM back in IDLE.
- **Flow control:** FIFO_DEPTH=4, RTS_MARGIN=2, Ready=0, send 0x01..0x05.
  - RTS falls 1 cycle after the 2nd push.
  - The 5th word pulses Overrun.
  - Raising Ready then pops 0x01..0x04 in order.
- **Reset mid-frame:** assert Reset_n=0 during data bit 3 → Valid 0, RTS 1. A following clean frame 0x3C is received correctly.
